// File: rtl/pipelined_ripple_adder.sv
// WIDTH-bit add/subtract built as a chain of CHUNK-bit ripple slices, one slice
// resolved per clock, with a global-stall valid/ready handshake on both sides.
module pipelined_ripple_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTAGE = WIDTH / CHUNK;

  generate
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
      $error("pipelined_ripple_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  // Bit-serial ripple over one slice; returns {carry into slice MSB, carry out, sum}.
  function automatic logic [CHUNK+1:0] slice_add(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             c_in
  );
    logic [CHUNK-1:0] s;
    logic             c;
    logic             c_msb;
    s     = '0;
    c     = c_in;
    c_msb = c_in;
    for (int i = 0; i < CHUNK; i++) begin
      c_msb = c;
      s[i]  = x[i] ^ y[i] ^ c;
      c     = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c_msb, c, s};
  endfunction

  logic              adv;
  logic [NSTAGE-1:0] vld_q, vld_d;
  logic [NSTAGE-1:0] carry_q, carry_d;
  logic [NSTAGE-1:0] cmsb_d;
  logic              ovf_q, ovf_d;
  logic [WIDTH-1:0]  a_q     [NSTAGE];
  logic [WIDTH-1:0]  a_d     [NSTAGE];
  logic [WIDTH-1:0]  b_q     [NSTAGE];
  logic [WIDTH-1:0]  b_d     [NSTAGE];
  logic [WIDTH-1:0]  sum_q   [NSTAGE];
  logic [WIDTH-1:0]  sum_d   [NSTAGE];
  logic [WIDTH-1:0]  sum_in_s[NSTAGE];
  logic [NSTAGE-1:0] cin_s;
  logic [CHUNK+1:0]  slice_res_s;

  // One global advance: the whole pipe moves unless a result is stuck at the output.
  assign adv = ~vld_q[NSTAGE-1] | out_ready;

  // Operands, carry and partial sum presented to each slice: ports for slice 0,
  // the previous stage register for every later slice. Subtract folds into b/cin here.
  always_comb begin
    a_d[0]      = a;
    b_d[0]      = b ^ {WIDTH{sub}};
    cin_s[0]    = cin ^ sub;
    sum_in_s[0] = '0;
    vld_d[0]    = in_valid;
    for (int p = 1; p < NSTAGE; p++) begin
      a_d[p]      = a_q[p-1];
      b_d[p]      = b_q[p-1];
      cin_s[p]    = carry_q[p-1];
      sum_in_s[p] = sum_q[p-1];
      vld_d[p]    = vld_q[p-1];
    end
  end

  // Resolve slice p in stage p; completed low slices ride along unchanged.
  always_comb begin
    slice_res_s = '0;
    for (int p = 0; p < NSTAGE; p++) begin
      slice_res_s                = slice_add(a_d[p][p*CHUNK +: CHUNK],
                                             b_d[p][p*CHUNK +: CHUNK], cin_s[p]);
      sum_d[p]                   = sum_in_s[p];
      sum_d[p][p*CHUNK +: CHUNK] = slice_res_s[CHUNK-1:0];
      carry_d[p]                 = slice_res_s[CHUNK];
      cmsb_d[p]                  = slice_res_s[CHUNK+1];
    end
    ovf_d = cmsb_d[NSTAGE-1] ^ carry_d[NSTAGE-1];
  end

  // Stage registers; the last stage doubles as the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      sum_q   <= '{default: '0};
    end else if (adv) begin
      vld_q   <= vld_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = vld_q[NSTAGE-1];
  assign sum       = sum_q[NSTAGE-1];
  assign cout      = carry_q[NSTAGE-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Scoreboard bench for pipelined_ripple_adder: 16/4 main instance plus
// (16,16), (16,1) and (8,2) instances for latency and wrap checks.
module tb_pipelined_ripple_adder;

  logic        clk, rst, in_valid, cin, sub, out_ready;
  logic        in_ready, out_valid, cout, ovf;
  logic [15:0] a, b, sum;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [17:0] exp_q[$];

  logic [2:0]  sw_in_valid;
  wire  [2:0]  sw_in_ready, sw_out_valid, sw_cout, sw_ovf;
  wire  [15:0] sw_sum0, sw_sum1;
  wire  [7:0]  sw_sum2;

  pipelined_ripple_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf));

  pipelined_ripple_adder #(.WIDTH(16), .CHUNK(16)) dut_w16c16 (
    .clk(clk), .rst(rst), .in_valid(sw_in_valid[0]), .in_ready(sw_in_ready[0]),
    .a(16'hFFFF), .b(16'h0001), .cin(1'b0), .sub(1'b0), .out_valid(sw_out_valid[0]),
    .out_ready(1'b1), .sum(sw_sum0), .cout(sw_cout[0]), .ovf(sw_ovf[0]));

  pipelined_ripple_adder #(.WIDTH(16), .CHUNK(1)) dut_w16c1 (
    .clk(clk), .rst(rst), .in_valid(sw_in_valid[1]), .in_ready(sw_in_ready[1]),
    .a(16'hFFFF), .b(16'h0001), .cin(1'b0), .sub(1'b0), .out_valid(sw_out_valid[1]),
    .out_ready(1'b1), .sum(sw_sum1), .cout(sw_cout[1]), .ovf(sw_ovf[1]));

  pipelined_ripple_adder #(.WIDTH(8), .CHUNK(2)) dut_w8c2 (
    .clk(clk), .rst(rst), .in_valid(sw_in_valid[2]), .in_ready(sw_in_ready[2]),
    .a(8'hFF), .b(8'h01), .cin(1'b0), .sub(1'b0), .out_valid(sw_out_valid[2]),
    .out_ready(1'b1), .sum(sw_sum2), .cout(sw_cout[2]), .ovf(sw_ovf[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Reference result {ovf, cout, sum} from wide arithmetic and operand signs.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c, input logic s);
    logic [15:0] yy;
    logic        cc;
    logic [16:0] full;
    logic        o;
    yy   = s ? ~y : y;
    cc   = s ? ~c : c;
    full = {1'b0, x} + {1'b0, yy} + {16'd0, cc};
    o    = (x[15] == yy[15]) && (full[15] != x[15]);
    return {o, full};
  endfunction

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin : sb
    logic [17:0] e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_extra got %h want none", {ovf, cout, sum});
        end else begin
          e = exp_q.pop_front();
          if ({ovf, cout, sum} !== e) begin
            n_err++;
            $display("FAIL sb_result got %h want %h", {ovf, cout, sum}, e);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] xa, input logic [15:0] xb,
                      input logic xc, input logic xs);
    logic acc;
    acc = 1'b0;
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
    for (int w = 0; w < 100 && !acc; w++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout got in_ready=0 want 1");
    end
  endtask

  task automatic wait_out(output int n);
    n = 0;
    for (int w = 1; w <= 60; w++) begin
      @(negedge clk);
      n = w;
      if (out_valid) break;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int w = 0; w < 200 && exp_q.size() != 0; w++) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++;
    if ({ovf, cout, sum} !== 18'h00000) begin
      n_err++; $display("FAIL reset_outputs got %h want 00000", {ovf, cout, sum});
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", in_ready); end
    tick();
  endtask

  task automatic test_carry_chain();
    int lat;
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_out(lat);
    n_cmp++;
    if (lat !== 4) begin n_err++; $display("FAIL chain_latency got %0d want 4", lat); end
    n_cmp++;
    if ({ovf, cout, sum} !== 18'h10000) begin
      n_err++; $display("FAIL chain_result got %h want 10000", {ovf, cout, sum});
    end
    drain();
  endtask

  task automatic test_ovf_sub();
    logic [17:0] tbl [3];
    int          lat;
    tbl[0] = {1'b1, 1'b0, 16'h8000};
    tbl[1] = {1'b0, 1'b0, 16'hFFFE};
    tbl[2] = {1'b1, 1'b1, 16'h7FFF};
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      wait_out(lat);
      n_cmp++;
      if ({ovf, cout, sum} !== tbl[k]) begin
        n_err++; $display("FAIL ovf_sub[%0d] got %h want %h", k, {ovf, cout, sum}, tbl[k]);
      end
    end
    tick();
    drain();
  endtask

  task automatic test_streaming();
    int first_acc, first_out, run;
    first_acc = 0; first_out = 0; run = 0;
    out_ready = 1'b1;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          send(16'($urandom), 16'($urandom), k[1], k[0]);
          if (k == 0) first_acc = cyc;
        end
      end
      begin
        for (int w = 0; w < 60 && !out_valid; w++) @(negedge clk);
        if (out_valid) begin
          first_out = cyc;
          run = 1;
          for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) run++;
          end
        end
      end
    join
    n_cmp++;
    if (first_out - first_acc !== 3) begin
      n_err++; $display("FAIL stream_latency got %0d want 3", first_out - first_acc);
    end
    n_cmp++;
    if (run !== 8) begin n_err++; $display("FAIL stream_run got %0d want 8", run); end
    tick();
    drain();
  endtask

  task automatic test_backpressure();
    logic [18:0] snap;
    int          seen;
    out_ready = 1'b0;
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    send(16'h0FF0, 16'h0010, 1'b1, 1'b0);
    send(16'h0000, 16'h0001, 1'b0, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 1'b0);
    a = 16'hFFFE; b = 16'h0001; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    snap = {out_valid, ovf, cout, sum};
    n_cmp++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_full got %b want 1", out_valid); end
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b0 || {out_valid, ovf, cout, sum} !== snap) begin
        n_err++;
        $display("FAIL bp_hold[%0d] got rdy=%b out=%h want rdy=0 out=%h",
                 s, in_ready, {out_valid, ovf, cout, sum}, snap);
      end
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b11) begin
      n_err++; $display("FAIL bp_swap got %b want 11", {in_ready, out_valid});
    end
    tick();
    in_valid = 1'b0;
    drain();
    seen = 0;
    for (int w = 0; w < 6; w++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_err++; $display("FAIL bp_dup got %0d want 0", seen); end
    tick();
  endtask

  task automatic test_reset_midflight();
    int seen, lat;
    out_ready = 1'b1;
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    send(16'h0003, 16'h0009, 1'b1, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, ovf, cout, sum} !== 19'h00000) begin
      n_err++; $display("FAIL rst_flight_out got %h want 00000", {out_valid, ovf, cout, sum});
    end
    seen = 0;
    for (int w = 0; w < 8; w++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_err++; $display("FAIL rst_flight_ghost got %0d want 0", seen); end
    tick();
    send(16'h1234, 16'h4321, 1'b1, 1'b0);
    wait_out(lat);
    n_cmp++;
    if ({ovf, cout, sum} !== 18'h05556) begin
      n_err++; $display("FAIL rst_flight_next got %h want 05556", {ovf, cout, sum});
    end
    tick();
    drain();
  endtask

  task automatic test_reset_stall();
    int seen;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(16'h00F0 + 16'(k), 16'h0F0F, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_stall_pre got %b want 0", in_ready); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, ovf, cout, sum} !== 20'h80000) begin
      n_err++;
      $display("FAIL rst_stall_out got %h want 80000", {in_ready, out_valid, ovf, cout, sum});
    end
    seen = 0;
    for (int w = 0; w < 6; w++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_err++; $display("FAIL rst_stall_ghost got %0d want 0", seen); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      a         = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      b         = ($urandom_range(0, 7) == 0) ? 16'h0001 : 16'($urandom);
      cin       = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
  endtask

  task automatic test_param_sweep();
    int          lat_tbl [3];
    int          lat;
    logic        rdy;
    logic [15:0] s;
    lat_tbl[0] = 1; lat_tbl[1] = 16; lat_tbl[2] = 4;
    for (int i = 0; i < 3; i++) begin
      sw_in_valid[i] = 1'b1;
      @(negedge clk);
      rdy = sw_in_ready[i];
      tick();
      sw_in_valid[i] = 1'b0;
      lat = 0;
      for (int w = 1; w <= 40; w++) begin
        @(negedge clk);
        lat = w;
        if (sw_out_valid[i]) break;
      end
      case (i)
        0:       s = sw_sum0;
        1:       s = sw_sum1;
        default: s = {8'h00, sw_sum2};
      endcase
      n_cmp++;
      if (rdy !== 1'b1) begin n_err++; $display("FAIL sweep_ready[%0d] got %b want 1", i, rdy); end
      n_cmp++;
      if (lat !== lat_tbl[i]) begin
        n_err++; $display("FAIL sweep_latency[%0d] got %0d want %0d", i, lat, lat_tbl[i]);
      end
      n_cmp++;
      if ({sw_ovf[i], sw_cout[i], s} !== 18'h10000) begin
        n_err++; $display("FAIL sweep_wrap[%0d] got %h want 10000", i, {sw_ovf[i], sw_cout[i], s});
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = 16'h0000; b = 16'h0000;
    cin = 1'b0; sub = 1'b0; out_ready = 1'b1; sw_in_valid = 3'b000;
    test_reset();
    test_carry_chain();
    test_ovf_sub();
    test_streaming();
    test_backpressure();
    test_reset_midflight();
    test_reset_stall();
    test_random();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
